// File: rtl/uio_cmd_master.sv
// Host-side initiator of the user-IO command channel: sends one command word plus
// cmd_len data words to an hps_io-style responder and returns each captured io_din word.
module uio_cmd_master #(
    parameter int LEN_W   = 10,
    parameter int GAP     = 2,
    parameter int END_GAP = 2
) (
    input  logic             clk_sys,
    input  logic             reset_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [7:0]       cmd_code,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic [15:0]      wr_data,
    input  logic             wr_valid,
    output logic             wr_ready,
    output logic [15:0]      rd_data,
    output logic             rd_valid,
    output logic [LEN_W-1:0] rd_idx,
    output logic             busy,
    output logic             done,
    input  logic             abort,
    output logic             uio_ena,
    output logic             io_strobe,
    output logic [15:0]      io_dout,
    input  logic [15:0]      io_din,
    input  logic             io_wait
);

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_STROBE, S_GAP, S_WAIT_WR, S_END
    } state_t;

    localparam int CNT_W = 8;
    // GAP state covers GAP-1 cycles, END covers END_GAP cycles; both count down to zero.
    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP - 2);
    localparam logic [CNT_W-1:0] END_LOAD = CNT_W'(END_GAP - 1);

    state_t           state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] n_q, n_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             uio_ena_q, uio_ena_d;
    logic             io_strobe_q, io_strobe_d;
    logic [15:0]      io_dout_q, io_dout_d;
    logic             wr_ready_q, wr_ready_d;
    logic             cap_q, cap_d;
    logic             rd_valid_q, rd_valid_d;
    logic [15:0]      rd_data_q, rd_data_d;
    logic [LEN_W-1:0] rd_idx_q, rd_idx_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             cmd_ready_q, cmd_ready_d;
    logic             to_end;

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        n_d         = n_q;
        cnt_d       = cnt_q;
        uio_ena_d   = uio_ena_q;
        io_strobe_d = 1'b0;
        io_dout_d   = io_dout_q;
        wr_ready_d  = wr_ready_q;
        cap_d       = io_strobe_q;
        rd_valid_d  = 1'b0;
        rd_data_d   = rd_data_q;
        rd_idx_d    = rd_idx_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        cmd_ready_d = cmd_ready_q;
        to_end      = 1'b0;

        // Capture runs independently of the FSM so an abort still delivers the last response.
        if (cap_q) begin
            rd_valid_d = 1'b1;
            rd_data_d  = io_din;
            rd_idx_d   = n_q;
        end

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    len_d       = cmd_len;
                    n_d         = '0;
                    uio_ena_d   = 1'b1;
                    io_dout_d   = {8'h00, cmd_code};
                    cmd_ready_d = 1'b0;
                    busy_d      = 1'b1;
                    state_d     = S_SETUP;
                end
            end
            S_SETUP: begin
                if (abort) begin
                    to_end = 1'b1;
                end else if (!io_wait) begin
                    io_strobe_d = 1'b1;
                    state_d     = S_STROBE;
                end
            end
            S_STROBE: begin
                if (abort) begin
                    to_end = 1'b1;
                end else begin
                    cnt_d   = GAP_LOAD;
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (abort) begin
                    to_end = 1'b1;
                end else if (cnt_q == '0) begin
                    if (n_q == len_q) begin
                        to_end = 1'b1;
                    end else begin
                        n_d        = (n_q == '1) ? n_q : n_q + 1'b1;
                        wr_ready_d = 1'b1;
                        state_d    = S_WAIT_WR;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_WAIT_WR: begin
                if (abort) begin
                    to_end = 1'b1;
                end else if (wr_valid) begin
                    wr_ready_d = 1'b0;
                    io_dout_d  = wr_data;
                    if (io_wait) begin
                        state_d = S_SETUP;
                    end else begin
                        io_strobe_d = 1'b1;
                        state_d     = S_STROBE;
                    end
                end
            end
            S_END: begin
                if (cnt_q == '0) begin
                    done_d      = 1'b1;
                    cmd_ready_d = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (to_end) begin
            uio_ena_d   = 1'b0;
            io_strobe_d = 1'b0;
            wr_ready_d  = 1'b0;
            cnt_d       = END_LOAD;
            state_d     = S_END;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            n_q         <= '0;
            cnt_q       <= '0;
            uio_ena_q   <= 1'b0;
            io_strobe_q <= 1'b0;
            io_dout_q   <= '0;
            wr_ready_q  <= 1'b0;
            cap_q       <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
            rd_idx_q    <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cmd_ready_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            n_q         <= n_d;
            cnt_q       <= cnt_d;
            uio_ena_q   <= uio_ena_d;
            io_strobe_q <= io_strobe_d;
            io_dout_q   <= io_dout_d;
            wr_ready_q  <= wr_ready_d;
            cap_q       <= cap_d;
            rd_valid_q  <= rd_valid_d;
            rd_data_q   <= rd_data_d;
            rd_idx_q    <= rd_idx_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            cmd_ready_q <= cmd_ready_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign wr_ready  = wr_ready_q;
    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign rd_idx    = rd_idx_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign uio_ena   = uio_ena_q;
    assign io_strobe = io_strobe_q;
    assign io_dout   = io_dout_q;

endmodule
